// File: rtl/vga_pkg.sv
// vga_pkg: shared playfield geometry, derived sizes and coordinate/address types
// for the Pong frame-buffer addressing logic.
package vga_pkg;

  localparam int H_RES   = 200;
  localparam int V_RES   = 150;
  localparam int COORD_W = 9;
  localparam int ADDR_W  = 16;

  // Number of pixels in the frame buffer; the largest legal address is FB_SIZE-1.
  localparam int FB_SIZE = H_RES * V_RES;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;

endpackage

// File: rtl/vga_mul_hres.sv
// vga_mul_hres: combinational constant multiplier p = y * H_RES, built only
// from shifted copies of y (one per set bit of H_RES), never a generic multiplier.
// For H_RES = 200 this reduces to (y<<7) + (y<<6) + (y<<3).
module vga_mul_hres #(
  parameter int H_RES   = vga_pkg::H_RES,
  parameter int COORD_W = vga_pkg::COORD_W,
  parameter int PROD_W  = COORD_W + $clog2(H_RES)
) (
  input  logic [COORD_W-1:0] y,
  output logic [PROD_W-1:0]  p
);

  // Sum y shifted by the position of every set bit in the constant row stride.
  always_comb begin
    p = '0;
    for (int i = 0; i < 31; i++) begin
      if (H_RES[i]) begin
        p = p + (PROD_W'(y) << i);
      end
    end
  end

endmodule

// File: rtl/vga_addr.sv
// vga_addr: turns a playfield coordinate (posx, posy) into a row-major
// frame-buffer address posy*H_RES + posx, registered with one cycle of latency.
// Out-of-range coordinates flag oob and force the address to 0 so the RAM is
// never driven outside the buffer.
module vga_addr #(
  parameter int H_RES   = vga_pkg::H_RES,
  parameter int V_RES   = vga_pkg::V_RES,
  parameter int COORD_W = vga_pkg::COORD_W,
  parameter int ADDR_W  = vga_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] posx,
  input  logic [COORD_W-1:0] posy,
  output logic [ADDR_W-1:0]  eff,
  output logic               out_valid,
  output logic               oob
);

  localparam int PROD_W = COORD_W + $clog2(H_RES);
  localparam int SUM_W  = PROD_W + 1;

  logic [PROD_W-1:0] row_base;
  logic [SUM_W-1:0]  full_addr;
  logic [ADDR_W-1:0] addr_next;
  logic              oob_next;

  vga_mul_hres #(
    .H_RES  (H_RES),
    .COORD_W(COORD_W),
    .PROD_W (PROD_W)
  ) u_mul (
    .y(posy),
    .p(row_base)
  );

  // Add the column to the row base and range-check the coordinate.
  always_comb begin
    full_addr = SUM_W'(row_base) + SUM_W'(posx);
    oob_next  = (int'(posx) >= H_RES) || (int'(posy) >= V_RES);
    addr_next = oob_next ? '0 : ADDR_W'(full_addr);
  end

  // Output registers: reset wins over in_valid; idle cycles hold eff/oob.
  always_ff @(posedge clk) begin
    if (rst) begin
      eff       <= '0;
      oob       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        eff <= addr_next;
        oob <= oob_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_addr.sv
// tb_vga_addr: directed-vector bench for vga_addr with hand-computed addresses.
module tb_vga_addr;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [8:0]  posx;
  logic [8:0]  posy;
  logic [15:0] eff;
  logic        out_valid;
  logic        oob;

  int check_count = 0;
  int error_count = 0;

  vga_addr dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .posx     (posx),
    .posy     (posy),
    .eff      (eff),
    .out_valid(out_valid),
    .oob      (oob)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Directed vectors: x, y, expected eff, expected oob.
  typedef struct {
    int x;
    int y;
    int exp_eff;
    bit exp_oob;
  } vec_t;

  vec_t vecs[10] = '{
    '{20,  10,  2020,  1'b0},
    '{199, 149, 29999, 1'b0},
    '{100, 100, 20100, 1'b0},
    '{0,   0,   0,     1'b0},
    '{1,   0,   1,     1'b0},
    '{0,   1,   200,   1'b0},
    '{200, 0,   0,     1'b1},
    '{0,   150, 0,     1'b1},
    '{511, 511, 0,     1'b1},
    '{199, 149, 29999, 1'b0}
  };

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample 1 ns after the
  // following rising edge, when the registered result for them is visible.
  task automatic applyStimulus(input bit r, input bit v, input int x, input int y);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    posx     = 9'(x);
    posy     = 9'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    posx     = '0;
    posy     = '0;

    // Two cycles of reset, checking outputs during reset.
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("reset_eff", int'(eff), 0);
    checkOutput("reset_oob", int'(oob), 0);
    checkOutput("reset_valid", int'(out_valid), 0);
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("post_reset_eff", int'(eff), 0);
    checkOutput("post_reset_valid", int'(out_valid), 0);

    // Back-to-back vectors, each result checked one cycle after its input.
    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b1, vecs[i].x, vecs[i].y);
      checkOutput($sformatf("eff_%0d_%0d", vecs[i].x, vecs[i].y), int'(eff), vecs[i].exp_eff);
      checkOutput($sformatf("oob_%0d_%0d", vecs[i].x, vecs[i].y), int'(oob), int'(vecs[i].exp_oob));
      checkOutput($sformatf("valid_%0d_%0d", vecs[i].x, vecs[i].y), int'(out_valid), 1);
    end

    // Idle cycle after (50,2): eff holds 450 while out_valid drops.
    applyStimulus(1'b0, 1'b1, 50, 2);
    checkOutput("eff_50_2", int'(eff), 450);
    applyStimulus(1'b0, 1'b0, 7, 7);
    checkOutput("hold_eff", int'(eff), 450);
    checkOutput("hold_oob", int'(oob), 0);
    checkOutput("hold_valid", int'(out_valid), 0);

    // Reset together with a valid input discards it.
    applyStimulus(1'b1, 1'b1, 10, 10);
    checkOutput("rst_drop_valid", int'(out_valid), 0);
    checkOutput("rst_drop_eff", int'(eff), 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("after_rst_valid", int'(out_valid), 0);

    // First valid input after reset appears one cycle later.
    applyStimulus(1'b0, 1'b1, 3, 4);
    checkOutput("eff_3_4", int'(eff), 803);
    checkOutput("valid_3_4", int'(out_valid), 1);
    applyStimulus(1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/vga_addr.md
# vga_addr

Pixel-address generator for the Pong frame buffer. Converts a screen coordinate (posx, posy) on the 200 x 150 playfield into a linear, row-major frame-buffer address: eff = posy * 200 + posx. It sits between the VGA/game coordinate logic and the frame-buffer RAM address port. The output is registered, with range checking and a valid flag.

## Interface
Parameters:
- H_RES, default 200: pixels per line; row stride of the address.
- V_RES, default 150: number of lines.
- COORD_W, default 9: width of posx/posy.
- ADDR_W, default 16: width of eff; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  posx/posy are valid this cycle.
- posx  in  COORD_W  column, unsigned, 0..H_RES-1 legal.
- posy  in  COORD_W  row, unsigned, 0..V_RES-1 legal.
- eff  out  ADDR_W  linear address posy*H_RES + posx.
- out_valid  out  1  eff/oob correspond to a sample accepted one cycle earlier.
- oob  out  1  accepted coordinate was out of range.

## Operation
- Arithmetic is unsigned. Compute posy*H_RES at full width (COORD_W + clog2(H_RES) bits), then add posx, then truncate to ADDR_W.
  - Truncation is lossless for legal inputs; the maximum is 149*200+199 = 29999.
- Multiplication by the constant H_RES is a shift-add. For 200 this is (y<<7)+(y<<6)+(y<<3). No generic multiplier is used.
- Range check: oob = (posx >= H_RES) || (posy >= V_RES).
  - When oob, eff = 0 so the RAM is never addressed outside the buffer.
- When in_valid = 0, the registers eff and oob hold their previous values. out_valid is 0 in the next cycle.
- No back-pressure and no handshake beyond in_valid. One result is produced per accepted input, every cycle if desired.

## Timing
- Latency is exactly 1 clock. Inputs sampled at rising edge N appear on eff/oob/out_valid after edge N. They are valid during cycle N+1.
- Reset (rst = 1 at a rising edge) sets eff = 0, oob = 0 and out_valid = 0.
- Reset takes priority over in_valid in the same cycle. An input presented during reset is discarded.
- Reset asserted mid-stream drops the in-flight result. The first valid output after reset comes one cycle after the first in_valid sampled with rst = 0.
- Back-to-back inputs give back-to-back outputs, with no bubbles.
- Boundary cases:
  - (0,0) gives 0.
  - (H_RES-1, V_RES-1) gives H_RES*V_RES-1.
  - posx = H_RES or posy = V_RES, including the maximum value 511, gives oob = 1 and eff = 0.

## Structure
- Shared package vga_pkg holds:
  - H_RES, V_RES, COORD_W, ADDR_W;
  - the derived FB_SIZE = H_RES*V_RES;
  - a coordinate typedef (COORD_W-bit unsigned) and an address typedef (ADDR_W-bit unsigned).
- One combinational sub-module, vga_mul_hres: the constant shift-add multiplier y -> y*H_RES, full width.
- The top module adds posx, does the range check, and holds the output registers.

## Test plan
- Apply rst for 2 cycles, then release. Required: eff = 0, oob = 0, out_valid = 0 during and right after reset.
- Apply in_valid with these inputs, one per cycle. Required one cycle later, with oob = 0 and out_valid = 1:
  - (20,10) gives 2020.
  - (199,149) gives 29999.
  - (100,100) gives 20100.
- Apply (0,0), (1,0) and (0,1) back-to-back. Required: 0, 1 and 200 on consecutive cycles, out_valid held high.
- Apply out-of-range (200,0), (0,150) and (511,511). Required: eff = 0 and oob = 1 for each. Then (199,149) gives 29999 with oob = 0.
- Apply in_valid = 0 after (50,2). Required: 450 is held on eff, out_valid drops to 0 the next cycle.
- Assert rst in the same cycle as in_valid with (10,10). Required: no out_valid next cycle, eff = 0.
